// File: rtl/threshold_alarm_monitor_if.sv
// rtl/threshold_alarm_monitor_if.sv - sample stream, thresholds and status bundle for threshold_alarm_monitor
interface threshold_alarm_monitor_if #(
  parameter int N  = 8,
  parameter int CW = 8
);
  logic          clr;
  logic          in_valid;
  logic [N-1:0]  sample;
  logic [N-1:0]  thr_hi;
  logic [N-1:0]  thr_lo;
  logic          alarm;
  logic          alarm_rise;
  logic          alarm_fall;
  logic [N-1:0]  max_val;
  logic [N-1:0]  min_val;
  logic          stats_valid;
  logic [CW-1:0] event_cnt;

  modport master (
    output clr, in_valid, sample, thr_hi, thr_lo,
    input  alarm, alarm_rise, alarm_fall, max_val, min_val, stats_valid, event_cnt
  );

  modport slave (
    input  clr, in_valid, sample, thr_hi, thr_lo,
    output alarm, alarm_rise, alarm_fall, max_val, min_val, stats_valid, event_cnt
  );
endinterface

// File: rtl/threshold_alarm_monitor.sv
// rtl/threshold_alarm_monitor.sv - debounced hysteresis alarm with edge pulses, running min/max and event count
module threshold_alarm_monitor #(
  parameter int N   = 8,
  parameter int DEB = 4,
  parameter int CW  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  threshold_alarm_monitor_if.slave  bus
);
  localparam int             CNTW    = $clog2(DEB + 1);
  localparam logic [CNTW-1:0] DEB_C  = CNTW'(DEB);
  localparam logic [CNTW-1:0] ONE_C  = CNTW'(1);
  localparam logic [CW-1:0]   EVT_MAX = '1;

  typedef enum logic [1:0] {NORMAL, ARMING, ALARM, RELEASING} state_t;

  state_t          state;
  logic [CNTW-1:0] cnt;
  logic [CNTW-1:0] cnt_inc;
  logic            above;
  logic            below;
  logic            rise_evt;
  logic            fall_evt;

  // Equality never qualifies, so strict compares on both thresholds.
  always_comb begin
    above    = bus.sample > bus.thr_hi;
    below    = bus.sample < bus.thr_lo;
    cnt_inc  = cnt + ONE_C;
    rise_evt = 1'b0;
    fall_evt = 1'b0;
    if (bus.in_valid) begin
      case (state)
        NORMAL:    rise_evt = above && (DEB == 1);
        ARMING:    rise_evt = above && (cnt_inc == DEB_C);
        ALARM:     fall_evt = below && (DEB == 1);
        RELEASING: fall_evt = below && (cnt_inc == DEB_C);
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= NORMAL;
      cnt            <= '0;
      bus.alarm      <= 1'b0;
      bus.alarm_rise <= 1'b0;
      bus.alarm_fall <= 1'b0;
    end else begin
      bus.alarm_rise <= rise_evt;
      bus.alarm_fall <= fall_evt;
      if (rise_evt) begin
        state     <= ALARM;
        cnt       <= '0;
        bus.alarm <= 1'b1;
      end else if (fall_evt) begin
        state     <= NORMAL;
        cnt       <= '0;
        bus.alarm <= 1'b0;
      end else if (bus.in_valid) begin
        case (state)
          NORMAL: begin
            if (above) begin
              state <= ARMING;
              cnt   <= ONE_C;
            end
          end
          ARMING: begin
            if (above) begin
              cnt <= cnt_inc;
            end else begin
              state <= NORMAL;
              cnt   <= '0;
            end
          end
          ALARM: begin
            if (below) begin
              state <= RELEASING;
              cnt   <= ONE_C;
            end
          end
          RELEASING: begin
            if (below) begin
              cnt <= cnt_inc;
            end else begin
              state <= ALARM;
              cnt   <= '0;
            end
          end
          default: begin
            state <= NORMAL;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

  // A clr alongside an accepted sample restarts the stats from that sample.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.max_val     <= '0;
      bus.min_val     <= '1;
      bus.stats_valid <= 1'b0;
    end else if (bus.in_valid) begin
      bus.stats_valid <= 1'b1;
      if (!bus.stats_valid || bus.clr) begin
        bus.max_val <= bus.sample;
        bus.min_val <= bus.sample;
      end else begin
        if (bus.sample > bus.max_val) bus.max_val <= bus.sample;
        if (bus.sample < bus.min_val) bus.min_val <= bus.sample;
      end
    end else if (bus.clr) begin
      bus.max_val     <= '0;
      bus.min_val     <= '1;
      bus.stats_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.event_cnt <= '0;
    end else if (bus.clr) begin
      bus.event_cnt <= rise_evt ? CW'(1) : '0;
    end else if (rise_evt && (bus.event_cnt != EVT_MAX)) begin
      bus.event_cnt <= bus.event_cnt + CW'(1);
    end
  end
endmodule

// File: tb/tb_threshold_alarm_monitor.sv
// tb/tb_threshold_alarm_monitor.sv - scoreboard bench for threshold_alarm_monitor (CW=8 and CW=2 instances)
module tb_threshold_alarm_monitor;
  localparam int DEB = 3;
  localparam logic [7:0] THR_HI = 8'd100;
  localparam logic [7:0] THR_LO = 8'd50;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   fails  = 0;

  threshold_alarm_monitor_if #(.N(8), .CW(8)) bus8 ();
  threshold_alarm_monitor_if #(.N(8), .CW(2)) bus2 ();

  threshold_alarm_monitor #(.N(8), .DEB(DEB), .CW(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  threshold_alarm_monitor #(.N(8), .DEB(DEB), .CW(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model state: 0 NORMAL, 1 ARMING, 2 ALARM, 3 RELEASING
  int         m_state, m_cnt, m_evt, m_evt2;
  logic       m_alarm, m_rise, m_fall, m_sv;
  logic [7:0] m_max, m_min;

  logic [29:0] exp_q[$];
  logic [29:0] obs_q[$];
  logic [29:0] e, o;

  task automatic drive(input bit rst, input bit v, input logic [7:0] s, input bit c);
    rst_n         = !rst;
    bus8.in_valid = v;  bus2.in_valid = v;
    bus8.sample   = s;  bus2.sample   = s;
    bus8.clr      = c;  bus2.clr      = c;
    if (rst) begin
      m_state = 0; m_cnt = 0; m_alarm = 0; m_rise = 0; m_fall = 0;
      m_max = 8'h00; m_min = 8'hff; m_sv = 0; m_evt = 0; m_evt2 = 0;
    end else begin
      m_rise = 0;
      m_fall = 0;
      if (v) begin
        case (m_state)
          0: if (s > THR_HI) begin
               if (DEB == 1) begin m_state = 2; m_alarm = 1; m_rise = 1; end
               else begin m_state = 1; m_cnt = 1; end
             end
          1: if (s > THR_HI) begin
               m_cnt++;
               if (m_cnt == DEB) begin m_state = 2; m_cnt = 0; m_alarm = 1; m_rise = 1; end
             end else begin m_state = 0; m_cnt = 0; end
          2: if (s < THR_LO) begin
               if (DEB == 1) begin m_state = 0; m_alarm = 0; m_fall = 1; end
               else begin m_state = 3; m_cnt = 1; end
             end
          default: if (s < THR_LO) begin
               m_cnt++;
               if (m_cnt == DEB) begin m_state = 0; m_cnt = 0; m_alarm = 0; m_fall = 1; end
             end else begin m_state = 2; m_cnt = 0; end
        endcase
        if (!m_sv || c) begin m_max = s; m_min = s; end
        else begin
          if (s > m_max) m_max = s;
          if (s < m_min) m_min = s;
        end
        m_sv = 1;
      end else if (c) begin
        m_max = 8'h00; m_min = 8'hff; m_sv = 0;
      end
      if (c) begin
        m_evt  = m_rise ? 1 : 0;
        m_evt2 = m_rise ? 1 : 0;
      end else if (m_rise) begin
        if (m_evt < 255) m_evt++;
        if (m_evt2 < 3) m_evt2++;
      end
    end
    exp_q.push_back({m_alarm, m_rise, m_fall, m_max, m_min, m_sv, 8'(m_evt), 2'(m_evt2)});
    @(posedge clk);
    #1;
    obs_q.push_back({bus8.alarm, bus8.alarm_rise, bus8.alarm_fall, bus8.max_val, bus8.min_val,
                     bus8.stats_valid, bus8.event_cnt, bus2.event_cnt});
    rst_n = 1'b1;
    bus8.in_valid = 1'b0; bus2.in_valid = 1'b0;
    bus8.clr      = 1'b0; bus2.clr      = 1'b0;
  endtask

  task automatic test_reset();
    drive(1, 0, 8'd0, 0);
    drive(1, 1, 8'd200, 1);
    checks++;
    if ({bus8.alarm, bus8.max_val, bus8.min_val, bus8.stats_valid, bus8.event_cnt} !== {1'b0, 8'h00, 8'hff, 1'b0, 8'h00}) begin
      fails++;
      $display("FAIL reset_values: observed alarm=%b max=%0d min=%0d sv=%b evt=%0d, required 0/0/255/0/0",
               bus8.alarm, bus8.max_val, bus8.min_val, bus8.stats_valid, bus8.event_cnt);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin fails++; $display("FAIL reset_sb: observed %h required %h", o, e); end
    end
  endtask

  task automatic test_assert();
    drive(1, 0, 8'd0, 0);
    drive(0, 1, 8'd101, 0);
    drive(0, 1, 8'd120, 0);
    drive(0, 1, 8'd105, 0);
    checks++;
    if ({bus8.alarm, bus8.alarm_rise, bus8.event_cnt} !== {1'b1, 1'b1, 8'd1}) begin
      fails++;
      $display("FAIL assert_edge: observed alarm=%b rise=%b evt=%0d, required 1/1/1", bus8.alarm, bus8.alarm_rise, bus8.event_cnt);
    end
    drive(0, 1, 8'd130, 0);
    checks++;
    if (bus8.alarm_rise !== 1'b0) begin
      fails++; $display("FAIL assert_pulse_width: observed rise=%b required 0", bus8.alarm_rise);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin fails++; $display("FAIL assert_sb: observed %h required %h", o, e); end
    end
  endtask

  task automatic test_run_break();
    logic [7:0] seq [6] = '{8'd101, 8'd102, 8'd100, 8'd110, 8'd111, 8'd112};
    drive(1, 0, 8'd0, 0);
    for (int i = 0; i < 6; i++) begin
      drive(0, 1, seq[i], 0);
      if (i == 4) begin
        checks++;
        if (bus8.alarm !== 1'b0) begin fails++; $display("FAIL run_break_early: observed alarm=%b required 0", bus8.alarm); end
      end
    end
    checks++;
    if (bus8.alarm_rise !== 1'b1) begin fails++; $display("FAIL run_break_rise: observed rise=%b required 1", bus8.alarm_rise); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin fails++; $display("FAIL run_break_sb: observed %h required %h", o, e); end
    end
  endtask

  task automatic test_release_gap();
    drive(1, 0, 8'd0, 0);
    for (int i = 0; i < 3; i++) drive(0, 1, 8'd120, 0);
    drive(0, 1, 8'd49, 0);
    for (int i = 0; i < 5; i++) drive(0, 0, 8'd0, 0);
    drive(0, 1, 8'd48, 0);
    drive(0, 1, 8'd10, 0);
    checks++;
    if ({bus8.alarm, bus8.alarm_fall} !== 2'b01) begin
      fails++; $display("FAIL release_fall: observed alarm=%b fall=%b required 0/1", bus8.alarm, bus8.alarm_fall);
    end
    for (int i = 0; i < 3; i++) drive(0, 1, 8'd120, 0);
    drive(0, 1, 8'd49, 0);
    drive(0, 1, 8'd50, 0);
    checks++;
    if ({bus8.alarm, bus8.alarm_fall} !== 2'b10) begin
      fails++; $display("FAIL release_abort: observed alarm=%b fall=%b required 1/0", bus8.alarm, bus8.alarm_fall);
    end
    for (int i = 0; i < 3; i++) drive(0, 1, 8'd49, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin fails++; $display("FAIL release_sb: observed %h required %h", o, e); end
    end
  endtask

  task automatic test_stats();
    drive(1, 0, 8'd0, 0);
    drive(0, 1, 8'd30, 0);
    drive(0, 1, 8'd200, 0);
    drive(0, 1, 8'd7, 0);
    checks++;
    if ({bus8.max_val, bus8.min_val, bus8.stats_valid} !== {8'd200, 8'd7, 1'b1}) begin
      fails++; $display("FAIL stats_minmax: observed max=%0d min=%0d sv=%b required 200/7/1", bus8.max_val, bus8.min_val, bus8.stats_valid);
    end
    drive(0, 1, 8'd60, 1);
    checks++;
    if ({bus8.max_val, bus8.min_val} !== {8'd60, 8'd60}) begin
      fails++; $display("FAIL stats_clr_valid: observed max=%0d min=%0d required 60/60", bus8.max_val, bus8.min_val);
    end
    drive(0, 1, 8'd0, 0);
    drive(0, 1, 8'd255, 0);
    drive(0, 0, 8'd0, 1);
    checks++;
    if ({bus8.max_val, bus8.min_val, bus8.stats_valid} !== {8'd0, 8'd255, 1'b0}) begin
      fails++; $display("FAIL stats_clr_idle: observed max=%0d min=%0d sv=%b required 0/255/0", bus8.max_val, bus8.min_val, bus8.stats_valid);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin fails++; $display("FAIL stats_sb: observed %h required %h", o, e); end
    end
  endtask

  task automatic test_mid_reset();
    drive(1, 0, 8'd0, 0);
    drive(0, 1, 8'd150, 0);
    drive(0, 1, 8'd150, 0);
    drive(1, 1, 8'd150, 0);
    drive(0, 1, 8'd150, 0);
    drive(0, 1, 8'd150, 0);
    checks++;
    if (bus8.alarm !== 1'b0) begin fails++; $display("FAIL mid_reset_noalarm: observed alarm=%b required 0", bus8.alarm); end
    drive(0, 1, 8'd150, 0);
    checks++;
    if (bus8.alarm_rise !== 1'b1) begin fails++; $display("FAIL mid_reset_rise: observed rise=%b required 1", bus8.alarm_rise); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin fails++; $display("FAIL mid_reset_sb: observed %h required %h", o, e); end
    end
  endtask

  task automatic test_event_sat();
    int want [4] = '{1, 2, 3, 3};
    drive(1, 0, 8'd0, 0);
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 3; i++) drive(0, 1, 8'd120, 0);
      checks++;
      if (bus2.event_cnt !== 2'(want[k])) begin
        fails++; $display("FAIL event_sat_%0d: observed evt=%0d required %0d", k, bus2.event_cnt, want[k]);
      end
      for (int i = 0; i < 3; i++) drive(0, 1, 8'd10, 0);
    end
    drive(0, 1, 8'd120, 0);
    drive(0, 1, 8'd120, 0);
    drive(0, 1, 8'd120, 1);
    checks++;
    if ({bus2.event_cnt, bus8.event_cnt} !== {2'd1, 8'd1}) begin
      fails++; $display("FAIL event_clr_rise: observed evt2=%0d evt8=%0d required 1/1", bus2.event_cnt, bus8.event_cnt);
    end
    drive(0, 0, 8'd0, 1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin fails++; $display("FAIL event_sb: observed %h required %h", o, e); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] s;
    drive(1, 0, 8'd0, 0);
    for (int i = 0; i < 200; i++) begin
      s = 8'($urandom_range(0, 255));
      drive(0, ($urandom_range(0, 3) != 0), s, ($urandom_range(0, 15) == 0));
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin fails++; $display("FAIL random_sb: observed %h required %h", o, e); end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus8.in_valid = 1'b0; bus2.in_valid = 1'b0;
    bus8.clr = 1'b0;      bus2.clr = 1'b0;
    bus8.sample = 8'd0;   bus2.sample = 8'd0;
    bus8.thr_hi = THR_HI; bus2.thr_hi = THR_HI;
    bus8.thr_lo = THR_LO; bus2.thr_lo = THR_LO;
    test_reset();
    test_assert();
    test_run_break();
    test_release_gap();
    test_stats();
    test_mid_reset();
    test_event_sat();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
